// File: rtl/cdc_rdptr_empty_fwft.sv
// ---------------------------------------------------------------------------
// cdc_rdptr_empty_fwft
//
// Read-clock-domain half of the dual-clock FIFO. It keeps the binary and Gray
// read pointers, computes the registered empty flag from the synchronised
// Gray write pointer, drives the one-cycle-latency memory read port, and turns
// the returned words into a first-word-fall-through valid/ready stream through
// a two-entry output buffer.
//
// Optional feature macro: CDC_RD_LEVEL_EN
//   defined   : rd_level / rd_almost_empty report registered occupancy
//   undefined : level logic is not built; rd_level and rd_almost_empty are 0
//
// Ports
//   rd_clk          read-domain clock
//   rd_rst          synchronous, active-low reset
//   rdq2_wrptr      Gray write pointer, already synchronised into rd_clk
//   rd_ptr          registered Gray read pointer (to the write domain)
//   rd_addr         memory read address (rbin without the wrap bit)
//   rd_en           memory read strobe (combinational)
//   rd_data_mem     memory read data, valid the cycle after rd_en
//   rd_empty        registered memory-empty flag
//   out_data        head-of-FIFO word
//   out_valid       out_data is valid
//   out_ready       consumer accepts; pop = out_valid & out_ready
//   rd_level        registered occupancy (memory + in flight + buffer)
//   rd_almost_empty registered, rd_level <= AE_THRESH
// ---------------------------------------------------------------------------
module cdc_rdptr_empty_fwft #(
    parameter int ADDRSIZE  = 4,
    parameter int DATAWIDTH = 32,
    parameter int AE_THRESH = 2
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic [ADDRSIZE:0]     rdq2_wrptr,
    output logic [ADDRSIZE:0]     rd_ptr,
    output logic [ADDRSIZE-1:0]   rd_addr,
    output logic                  rd_en,
    input  logic [DATAWIDTH-1:0]  rd_data_mem,
    output logic                  rd_empty,
    output logic [DATAWIDTH-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDRSIZE+1:0]   rd_level,
    output logic                  rd_almost_empty
);

    if (AE_THRESH < 0) begin : g_bad_ae_thresh
        $error("AE_THRESH must be non-negative");
    end

    logic [ADDRSIZE:0]    rbin;
    logic [ADDRSIZE:0]    rbinnext;
    logic [ADDRSIZE:0]    rgraynext;
    logic [1:0]           buf_count;
    logic                 inflight;
    logic [DATAWIDTH-1:0] buf0;     // oldest entry, drives out_data
    logic [DATAWIDTH-1:0] buf1;
    logic                 pop;
    logic                 can_issue;

    assign pop       = out_valid & out_ready;
    assign out_valid = (buf_count != 2'd0);
    assign out_data  = buf0;
    assign rd_addr   = rbin[ADDRSIZE-1:0];

    // credit = 2 - buf_count - inflight + pop > 0, rearranged to avoid
    // signed arithmetic.
    assign can_issue = ({1'b0, buf_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});

    // Gating with rd_rst keeps the strobe low during the first reset cycle,
    // before rd_empty has been forced high by the reset edge.
    assign rd_en = rd_rst & ~rd_empty & can_issue;

    assign rbinnext  = rbin + {{ADDRSIZE{1'b0}}, rd_en};
    assign rgraynext = rbinnext ^ (rbinnext >> 1);

    always_ff @(posedge rd_clk) begin
        if (!rd_rst) begin
            rbin     <= '0;
            rd_ptr   <= '0;
            rd_empty <= 1'b1;
            inflight <= 1'b0;
        end else begin
            rbin     <= rbinnext;
            rd_ptr   <= rgraynext;
            rd_empty <= (rgraynext == rdq2_wrptr);
            inflight <= rd_en;
        end
    end

    // Output buffer: push is the word returning from memory, pop is the
    // consumer handshake. The issue credit guarantees no push into a full
    // buffer, so only the listed cases can occur.
    always_ff @(posedge rd_clk) begin
        if (!rd_rst) begin
            buf_count <= 2'd0;
            buf0      <= '0;
            buf1      <= '0;
        end else begin
            case ({inflight, pop})
                2'b10: begin
                    if (buf_count == 2'd0) begin
                        buf0      <= rd_data_mem;
                        buf_count <= 2'd1;
                    end else begin
                        buf1      <= rd_data_mem;
                        buf_count <= 2'd2;
                    end
                end
                2'b01: begin
                    buf0      <= buf1;
                    buf_count <= buf_count - 2'd1;
                end
                2'b11: begin
                    if (buf_count == 2'd1) begin
                        buf0 <= rd_data_mem;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= rd_data_mem;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef CDC_RD_LEVEL_EN
    localparam int LVL_W = ADDRSIZE + 2;

    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] unread;
    logic [LVL_W-1:0]  level_next;

    // Gray to binary as a prefix XOR from the MSB down, done in log2 steps.
    always_comb begin
        wbin = rdq2_wrptr;
        for (int unsigned s = 1; s <= unsigned'(ADDRSIZE); s = s * 2)
            wbin = wbin ^ (wbin >> s);
    end

    assign unread     = wbin - rbin;
    assign level_next = {1'b0, unread}
                      + {{(LVL_W-1){1'b0}}, inflight}
                      + {{(LVL_W-2){1'b0}}, buf_count};

    always_ff @(posedge rd_clk) begin
        if (!rd_rst) begin
            rd_level        <= '0;
            rd_almost_empty <= 1'b1;
        end else begin
            rd_level        <= level_next;
            rd_almost_empty <= (level_next <= LVL_W'(AE_THRESH));
        end
    end
`else
    assign rd_level        = '0;
    assign rd_almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_rdptr_empty_fwft.sv
// ---------------------------------------------------------------------------
// tb_cdc_rdptr_empty_fwft
//
// Bench for cdc_rdptr_empty_fwft. The bench plays the write side: it owns a
// 16-word memory with one-cycle read latency and publishes its write count as
// a Gray pointer. A free-running monitor keeps a word queue and simple
// counters (words written, words read, words popped) and checks the stream,
// pointer, empty and level behaviour every cycle. Directed table vectors and
// hand-written sequences cover reset, latency, backpressure, wrap, level and
// mid-stream reset; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_cdc_rdptr_empty_fwft;

    localparam int AW = 4;
    localparam int DW = 32;

`ifdef CDC_RD_LEVEL_EN
    localparam bit LVL_EN = 1'b1;
`else
    localparam bit LVL_EN = 1'b0;
`endif

    logic          rd_clk = 1'b0;
    logic          rd_rst = 1'b0;
    logic [AW:0]   rdq2_wrptr;
    logic [AW:0]   rd_ptr;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic [DW-1:0] rd_data_mem = '0;
    logic          rd_empty;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW+1:0] rd_level;
    logic          rd_almost_empty;

    always #5 rd_clk = ~rd_clk;

    cdc_rdptr_empty_fwft #(
        .ADDRSIZE (AW),
        .DATAWIDTH(DW),
        .AE_THRESH(2)
    ) dut (
        .rd_clk         (rd_clk),
        .rd_rst         (rd_rst),
        .rdq2_wrptr     (rdq2_wrptr),
        .rd_ptr         (rd_ptr),
        .rd_addr        (rd_addr),
        .rd_en          (rd_en),
        .rd_data_mem    (rd_data_mem),
        .rd_empty       (rd_empty),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .rd_level       (rd_level),
        .rd_almost_empty(rd_almost_empty)
    );

    int checks = 0;
    int errors = 0;

    // Write-side model state
    logic [DW-1:0] mem [16];
    logic [DW-1:0] exp_q [$];
    int            wr_total = 0;   // words published since last reset
    int            popped   = 0;   // words handed to the consumer
    int            reads    = 0;   // read strobes seen
    bit            sb_en    = 1'b0;

    function automatic logic [AW:0] gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    assign rdq2_wrptr = gray(wr_total[AW:0]);

    always @(posedge rd_clk)
        if (rd_en) rd_data_mem <= mem[rd_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic push_words(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            mem[wr_total % 16] = base + DW'(i);
            exp_q.push_back(base + DW'(i));
            wr_total++;
        end
    endtask

    task automatic reset_all();
        rd_rst    = 1'b0;
        out_ready = 1'b0;
        wr_total  = 0;
        sb_en     = 1'b1;
        tick();
        tick();
        rd_rst = 1'b1;
    endtask

    // Monitor: samples at the falling edge, between input updates.
    logic [AW:0]   prev_wbin  = '0;
    bit            primed     = 1'b0;
    bit            prev_rstn  = 1'b0;
    bit            prev_valid = 1'b0;
    bit            prev_ready = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    int            exp_lvl    = 0;

    initial forever begin
        @(negedge rd_clk);
        if (primed) begin
            chk("mon_level", rd_level, LVL_EN ? exp_lvl : 0);
            chk("mon_almost_empty", rd_almost_empty, LVL_EN ? (exp_lvl <= 2) : 1'b0);
            chk("mon_rd_ptr", rd_ptr, gray(reads[AW:0]));
            chk("mon_rd_addr", rd_addr, reads[AW-1:0]);
            chk("mon_rd_empty", rd_empty, prev_rstn ? (reads[AW:0] == prev_wbin) : 1'b1);
            if (prev_rstn && prev_valid && !prev_ready) begin
                chk("mon_stall_valid", out_valid, 1'b1);
                chk("mon_stall_data", out_data, prev_data);
            end
        end
        chk("mon_rd_en_gate", rd_en & (rd_empty | ~rd_rst), 1'b0);
        if (rd_rst) begin
            exp_lvl = wr_total - popped;
            if (out_valid && out_ready) begin
                if (sb_en) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pop_underflow: got a pop, want none (t=%0t)", $time);
                    end else begin
                        chk("pop_data", out_data, exp_q.pop_front());
                    end
                end
                popped++;
            end
            if (rd_en) reads++;
        end else begin
            exp_lvl = 0;
            popped  = 0;
            reads   = 0;
            exp_q.delete();
        end
        prev_wbin  = wr_total[AW:0];
        prev_rstn  = rd_rst;
        prev_valid = out_valid;
        prev_ready = out_ready;
        prev_data  = out_data;
        primed     = 1'b1;
    end

    typedef struct {
        int          nw;     // words published at once
        bit          rdy;    // out_ready held during the wait
        logic [AW:0] ptr;    // expected Gray read pointer
        bit          empty;
        bit          valid;
        int          lvl;    // expected level when the feature is built
    } vec_t;

    vec_t vt [7];

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running, want finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{1, 1'b0, 5'b00001, 1'b1, 1'b1, 1};
        vt[1] = '{2, 1'b0, 5'b00011, 1'b1, 1'b1, 2};
        vt[2] = '{5, 1'b0, 5'b00011, 1'b0, 1'b1, 5};
        vt[3] = '{9, 1'b0, 5'b00011, 1'b0, 1'b1, 9};
        vt[4] = '{3, 1'b1, 5'b00010, 1'b1, 1'b0, 0};
        vt[5] = '{4, 1'b1, 5'b00110, 1'b1, 1'b0, 0};
        vt[6] = '{0, 1'b0, 5'b00000, 1'b1, 1'b0, 0};

        // Reset held 3 cycles with a non-zero write pointer (Gray 00011).
        rd_rst    = 1'b0;
        out_ready = 1'b0;
        sb_en     = 1'b0;
        wr_total  = 2;
        for (int c = 0; c < 3; c++) begin
            chk("rst_rd_en", rd_en, 1'b0);
            tick();
            chk("rst_rd_ptr", rd_ptr, 0);
            chk("rst_rd_empty", rd_empty, 1'b1);
            chk("rst_out_valid", out_valid, 1'b0);
            chk("rst_out_data", out_data, 0);
            chk("rst_rd_level", rd_level, 0);
            chk("rst_almost_empty", rd_almost_empty, LVL_EN ? 1'b1 : 1'b0);
            chk("rst_rd_en_after", rd_en, 1'b0);
        end
        rd_rst = 1'b1;
        tick();
        chk("rst_release_empty", rd_empty, 1'b0);

        // Table vectors: publish nw words, wait, compare settled state.
        for (int i = 0; i < 7; i++) begin
            logic [DW-1:0] base;
            base = 32'hA5A5_0000 + DW'(i * 256);
            reset_all();
            out_ready = vt[i].rdy;
            push_words(vt[i].nw, base);
            repeat (12) tick();
            chk("vec_rd_ptr", rd_ptr, vt[i].ptr);
            chk("vec_rd_empty", rd_empty, vt[i].empty);
            chk("vec_out_valid", out_valid, vt[i].valid);
            if (vt[i].valid) chk("vec_out_data", out_data, base);
            chk("vec_rd_level", rd_level, LVL_EN ? vt[i].lvl : 0);
            chk("vec_almost_empty", rd_almost_empty, LVL_EN ? (vt[i].lvl <= 2) : 1'b0);
        end

        // Single word fall-through latency.
        reset_all();
        out_ready = 1'b1;
        push_words(1, 32'hA5A5_0001);
        tick();
        chk("sw_c1_empty", rd_empty, 1'b0);
        chk("sw_c1_rd_en", rd_en, 1'b1);
        chk("sw_c1_valid", out_valid, 1'b0);
        tick();
        chk("sw_c2_valid", out_valid, 1'b0);
        tick();
        chk("sw_c3_valid", out_valid, 1'b1);
        chk("sw_c3_data", out_data, 32'hA5A5_0001);
        tick();
        chk("sw_c4_valid", out_valid, 1'b0);
        chk("sw_c4_rd_ptr", rd_ptr, 5'b00001);
        chk("sw_c4_empty", rd_empty, 1'b1);

        // Backpressure: 8 words, consumer stalled for 10 cycles.
        begin
            int en_cnt;
            en_cnt = 0;
            reset_all();
            push_words(8, 32'hB000_0000);
            for (int c = 0; c < 10; c++) begin
                @(negedge rd_clk);
                if (rd_en) en_cnt++;
                if (c >= 3) begin
                    chk("bp_hold_valid", out_valid, 1'b1);
                    chk("bp_hold_data", out_data, 32'hB000_0000);
                end
                tick();
            end
            chk("bp_rd_en_count", en_cnt, 2);
            out_ready = 1'b1;
            for (int k = 0; k < 8; k++) begin
                @(negedge rd_clk);
                chk("bp_stream_valid", out_valid, 1'b1);
                tick();
            end
            @(negedge rd_clk);
            chk("bp_stream_end", out_valid, 1'b0);
            chk("bp_all_out", exp_q.size(), 0);
            tick();
        end

        // Wrap-around: 40 words, writer at most 2 ahead of the consumer.
        begin
            int sent;
            bit seen31, wrapped;
            sent = 0; seen31 = 1'b0; wrapped = 1'b0;
            reset_all();
            out_ready = 1'b1;
            for (int c = 0; c < 400 && popped < 40; c++) begin
                if (sent < 40 && (wr_total - popped) < 2) begin
                    push_words(1, 32'hC000_0000 + DW'(sent));
                    sent++;
                end
                tick();
                if (rd_ptr == 5'b10000) seen31 = 1'b1;
                if (seen31 && rd_ptr == 5'b00000) wrapped = 1'b1;
            end
            chk("wrap_popped", popped, 40);
            chk("wrap_ptr_wrapped", wrapped, 1'b1);
            chk("wrap_queue_empty", exp_q.size(), 0);
        end

        // Level: 10 words with the consumer stalled, then 8 pops.
        begin
            int n;
            n = 0;
            reset_all();
            push_words(10, 32'hD000_0000);
            repeat (6) tick();
            chk("lvl_settle", rd_level, LVL_EN ? 10 : 0);
            chk("lvl_ae_low", rd_almost_empty, 1'b0);
            out_ready = 1'b1;
            for (int c = 0; c < 30 && n < 8; c++) begin
                @(negedge rd_clk);
                if (out_valid && out_ready) n++;
                tick();
                if (n == 8) out_ready = 1'b0;
            end
            repeat (3) tick();
            chk("lvl_pops", n, 8);
            chk("lvl_after_pops", rd_level, LVL_EN ? 2 : 0);
            chk("lvl_ae_high", rd_almost_empty, LVL_EN ? 1'b1 : 1'b0);
        end

        // Mid-stream reset with a word buffered and one in flight.
        begin
            bit found;
            found = 1'b0;
            reset_all();
            push_words(4, 32'hE000_0000);
            for (int c = 0; c < 10 && !found; c++) begin
                tick();
                if (out_valid) found = 1'b1;
            end
            chk("msr_reached_valid", found, 1'b1);
            rd_rst   = 1'b0;
            wr_total = 0;
            tick();
            rd_rst = 1'b1;
            chk("msr_out_valid", out_valid, 1'b0);
            chk("msr_rd_ptr", rd_ptr, 0);
            chk("msr_rd_empty", rd_empty, 1'b1);
            out_ready = 1'b1;
            repeat (3) begin
                tick();
                chk("msr_no_glitch", out_valid, 1'b0);
            end
        end

        // Randomized traffic with occasional resets.
        reset_all();
        for (int c = 0; c < 1500; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) begin
                rd_rst   = 1'b0;
                wr_total = 0;
                tick();
                rd_rst = 1'b1;
            end else begin
                if ($urandom_range(0, 1) == 1 && (wr_total - popped) < 16)
                    push_words(1, DW'($urandom()));
                tick();
            end
        end
        out_ready = 1'b1;
        for (int c = 0; c < 100 && (exp_q.size() != 0 || out_valid); c++)
            tick();
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("drain_out_valid", out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
